instr_encoder: RTL and testbench

Program loader for the soft MIPS core. It accepts symbolic instruction commands (mnemonic plus register and immediate fields) over a valid/ready handshake. It encodes each command into the 32-bit MIPS word that the core's instruction decoder consumes, and writes the words to consecutive instruction-memory addresses starting at 0. While a load is in progress it holds the core frozen through `cpu_enable`, and releases it once the program is written.

---
 rtl/instr_encoder_pkg.sv | 93 +++++++++
 rtl/instr_encode_comb.sv | 64 ++++++
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the program loader and the soft MIPS core decoder:
//   mnem_t      - symbolic mnemonic codes accepted on the command interface
//   OP_* / FN_* - primary opcode and R-type func field values
//   ld_state_t  - loader FSM states
//   r_word / i_word - field packers for R-type and I-type words
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_ADDU  = 5'd1,
    MN_SUB   = 5'd2,
    MN_AND   = 5'd3,
    MN_OR    = 5'd4,
    MN_XOR   = 5'd5,
    MN_NOR   = 5'd6,
    MN_SLT   = 5'd7,
    MN_SLTU  = 5'd8,
    MN_SLL   = 5'd9,
    MN_SLLV  = 5'd10,
    MN_SRL   = 5'd11,
    MN_SRA   = 5'd12,
    MN_JR    = 5'd13,
    MN_LW    = 5'd14,
    MN_SW    = 5'd15,
    MN_ADDI  = 5'd16,
    MN_ADDIU = 5'd17,
    MN_SLTI  = 5'd18,
    MN_SLTIU = 5'd19,
    MN_ORI   = 5'd20,
    MN_LUI   = 5'd21,
    MN_ANDI  = 5'd22,
    MN_XORI  = 5'd23,
    MN_BEQ   = 5'd24,
    MN_BNE   = 5'd25,
    MN_J     = 5'd26,
    MN_JAL   = 5'd27
  } mnem_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, shamt, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// -----------------------------------------------------------------------------
// instr_encode_comb
// Pure combinational map from a symbolic command to a 32-bit MIPS word.
//   mnem   in  5   mnemonic code (mnem_t values; 28-31 are invalid)
//   rs/rt/rd in 5  register fields
//   imm    in  16  immediate; [4:0] doubles as shamt for SLL/SRL/SRA
//   target in  26  J/JAL target
//   word   out 32  encoded instruction (all zeros for an invalid mnemonic)
//   valid  out 1   mnemonic was recognised
// -----------------------------------------------------------------------------
module instr_encode_comb
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  always_comb begin
    word  = 32'h0;
    valid = 1'b1;
    case (mnem)
      MN_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      MN_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      MN_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      MN_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      MN_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      MN_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      MN_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      MN_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      MN_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      // Constant shifts take the amount from the immediate and leave rs zero.
      MN_SLL:   word = r_word(5'd0, rt, rd, imm[4:0], FN_SLL);
      MN_SRL:   word = r_word(5'd0, rt, rd, imm[4:0], FN_SRL);
      MN_SRA:   word = r_word(5'd0, rt, rd, imm[4:0], FN_SRA);
      MN_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      MN_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_LW:    word = i_word(OP_LW, rs, rt, imm);
      MN_SW:    word = i_word(OP_SW, rs, rt, imm);
      MN_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      MN_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      MN_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      MN_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
      MN_ORI:   word = i_word(OP_ORI, rs, rt, imm);
      MN_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
      MN_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
      MN_XORI:  word = i_word(OP_XORI, rs, rt, imm);
      MN_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      MN_J:     word = {OP_J, target};
      MN_JAL:   word = {OP_JAL, target};
      default: begin
        word  = 32'h0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program loader: encodes symbolic commands and writes them to consecutive
// instruction-memory words from address 0, holding the core frozen meanwhile.
//   clk, rst_n         clock, async active-low reset
//   start              begin a session (honoured in IDLE/DONE only)
//   cmd_valid/ready    command handshake
//   cmd_mnem/rs/rt/rd/imm/target/last   command fields
//   imem_we/addr/wd    instruction-memory write port
//   cpu_enable         core run enable (low while loading)
//   done               one-cycle end-of-session pulse
//   error              sticky invalid-mnemonic / overflow flag
//   count              words written this session
//
// state | meaning
// IDLE  | waiting for start; core runs if a load has completed
// LOAD  | accepting commands, one write per accept
// FLUSH | last word being written, no more accepts
// DONE  | done pulse, core released
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_mnem,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [AWIDTH-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_enable,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   count
);

  localparam logic [AWIDTH:0] TOP_ADDR = {1'b0, {AWIDTH{1'b1}}};
  localparam logic [AWIDTH:0] CAPACITY = {1'b1, {AWIDTH{1'b0}}};

  ld_state_t state, state_nxt;

  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              accept;
  logic              launch;
  logic              at_top;

  logic              cmd_ready_nxt;
  logic              imem_we_nxt;
  logic [AWIDTH-1:0] imem_addr_nxt;
  logic [31:0]       imem_wd_nxt;
  logic              cpu_enable_nxt;
  logic              done_nxt;
  logic              error_nxt;
  logic [AWIDTH:0]   count_nxt;

  instr_encode_comb u_encode (
    .mnem   (cmd_mnem),
    .rs     (cmd_rs),
    .rt     (cmd_rt),
    .rd     (cmd_rd),
    .imm    (cmd_imm),
    .target (cmd_target),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  // cmd_ready is registered and high only in LOAD, so it qualifies the accept.
  assign accept = cmd_valid && cmd_ready;
  assign launch = start && (state == ST_IDLE || state == ST_DONE);
  assign at_top = (count == TOP_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && (cmd_last || at_top)) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the output registers; every output is a flop.
  always_comb begin
    cmd_ready_nxt  = (state_nxt == ST_LOAD);
    done_nxt       = (state_nxt == ST_DONE);
    imem_we_nxt    = accept;
    imem_addr_nxt  = imem_addr;
    imem_wd_nxt    = imem_wd;
    count_nxt      = count;
    error_nxt      = error;
    cpu_enable_nxt = cpu_enable;

    if (accept) begin
      imem_addr_nxt = count[AWIDTH-1:0];
      imem_wd_nxt   = enc_word;
      if (count != CAPACITY) count_nxt = count + 1'b1;
      // Overflow: the last free word was just taken and the program goes on.
      if (!enc_valid || (at_top && !cmd_last)) error_nxt = 1'b1;
    end

    if (launch) begin
      count_nxt = '0;
      error_nxt = 1'b0;
    end

    if (state_nxt == ST_DONE)   cpu_enable_nxt = 1'b1;
    else if (launch)            cpu_enable_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wd    <= 32'h0;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
    end else begin
      cmd_ready  <= cmd_ready_nxt;
      imem_we    <= imem_we_nxt;
      imem_addr  <= imem_addr_nxt;
      imem_wd    <= imem_wd_nxt;
      cpu_enable <= cpu_enable_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      count      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_mnem = '0;
  logic [4:0]  cmd_rs = '0;
  logic [4:0]  cmd_rt = '0;
  logic [4:0]  cmd_rd = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic        cmd_last = 1'b0;

  logic        d_ready, d_we, d_cpu_en, d_done, d_error;
  logic [9:0]  d_addr;
  logic [31:0] d_wd;
  logic [10:0] d_count;

  logic        s_ready, s_we, s_cpu_en, s_done, s_error;
  logic [1:0]  s_addr;
  logic [31:0] s_wd;
  logic [2:0]  s_count;

  logic        use_small = 1'b0;
  logic        o_ready, o_we, o_cpu_en, o_done, o_error;
  logic [10:0] o_addr;
  logic [31:0] o_wd;
  logic [10:0] o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AWIDTH(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(d_ready),
    .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(d_we), .imem_addr(d_addr), .imem_wd(d_wd), .cpu_enable(d_cpu_en),
    .done(d_done), .error(d_error), .count(d_count)
  );

  instr_encoder #(.AWIDTH(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(s_ready),
    .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(s_we), .imem_addr(s_addr), .imem_wd(s_wd), .cpu_enable(s_cpu_en),
    .done(s_done), .error(s_error), .count(s_count)
  );

  always_comb begin
    o_ready  = use_small ? s_ready  : d_ready;
    o_we     = use_small ? s_we     : d_we;
    o_cpu_en = use_small ? s_cpu_en : d_cpu_en;
    o_done   = use_small ? s_done   : d_done;
    o_error  = use_small ? s_error  : d_error;
    o_wd     = use_small ? s_wd     : d_wd;
    o_addr   = use_small ? {9'b0, s_addr}  : {1'b0, d_addr};
    o_count  = use_small ? {8'b0, s_count} : d_count;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one command (caller guarantees LOAD), then check the write in N+1.
  task automatic send(input string tag, input logic [4:0] m, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic lst,
                      input logic [10:0] exp_addr, input logic [31:0] exp_wd);
    cmd_mnem = m; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = lst; cmd_valid = 1'b1;
    check({tag, " ready"}, {31'b0, o_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_last = 1'b0;
    @(negedge clk);
    check({tag, " we"}, {31'b0, o_we}, 32'd1);
    check({tag, " addr"}, {21'b0, o_addr}, {21'b0, exp_addr});
    check({tag, " wd"}, o_wd, exp_wd);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ready"}, {31'b0, o_ready}, 32'd0);
    check({tag, " we"}, {31'b0, o_we}, 32'd0);
    check({tag, " addr"}, {21'b0, o_addr}, 32'd0);
    check({tag, " wd"}, o_wd, 32'd0);
    check({tag, " cpu_en"}, {31'b0, o_cpu_en}, 32'd0);
    check({tag, " done"}, {31'b0, o_done}, 32'd0);
    check({tag, " error"}, {31'b0, o_error}, 32'd0);
    check({tag, " count"}, {21'b0, o_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", {31'b0, o_ready}, 32'd0);
    check("idle cpu_en", {31'b0, o_cpu_en}, 32'd0);

    // Session 1: ADDI, ADD, SLL(last)
    pulse_start();
    check("s1 cpu_en load", {31'b0, o_cpu_en}, 32'd0);
    send("addi", 5'd16, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b0, 11'd0, 32'h20080005);
    send("add",  5'd0,  5'd8, 5'd9, 5'd10, 16'h0000, 26'h0, 1'b0, 11'd1, 32'h01095020);
    send("sll",  5'd9,  5'd7, 5'd3, 5'd2, 16'h0004, 26'h0, 1'b1, 11'd2, 32'h00031100);
    check("s1 flush ready", {31'b0, o_ready}, 32'd0);
    check("s1 flush cpu_en", {31'b0, o_cpu_en}, 32'd0);
    check("s1 flush done", {31'b0, o_done}, 32'd0);
    @(negedge clk);
    check("s1 done", {31'b0, o_done}, 32'd1);
    check("s1 cpu_en", {31'b0, o_cpu_en}, 32'd1);
    check("s1 count", {21'b0, o_count}, 32'd3);
    check("s1 error", {31'b0, o_error}, 32'd0);

    // Start from DONE goes straight back to LOAD
    pulse_start();
    check("s2 ready", {31'b0, o_ready}, 32'd1);
    check("s2 cpu_en", {31'b0, o_cpu_en}, 32'd0);
    check("s2 count clr", {21'b0, o_count}, 32'd0);
    check("s2 done clr", {31'b0, o_done}, 32'd0);
    send("beq", 5'd24, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 11'd0, 32'h1022FFFF);
    send("j",   5'd26, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 1'b1, 11'd1, 32'h08000010);
    check("s2 flush ready", {31'b0, o_ready}, 32'd0);
    check("s2 flush cpu_en", {31'b0, o_cpu_en}, 32'd0);
    @(negedge clk);
    check("s2 done", {31'b0, o_done}, 32'd1);
    check("s2 cpu_en", {31'b0, o_cpu_en}, 32'd1);
    check("s2 count", {21'b0, o_count}, 32'd2);
    @(negedge clk);
    check("s2 idle done", {31'b0, o_done}, 32'd0);
    check("s2 idle cpu_en", {31'b0, o_cpu_en}, 32'd1);
    check("s2 idle ready", {31'b0, o_ready}, 32'd0);
    check("s2 idle we", {31'b0, o_we}, 32'd0);

    // Session 3: invalid mnemonic, backpressure, start ignored in LOAD
    pulse_start();
    send("invalid", 5'd30, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0, 11'd0, 32'h00000000);
    check("inv error", {31'b0, o_error}, 32'd1);
    send("ori", 5'd20, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0, 1'b0, 11'd1, 32'h346400FF);
    check("ori error held", {31'b0, o_error}, 32'd1);
    @(negedge clk);
    check("gap1 we", {31'b0, o_we}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("gap2 we", {31'b0, o_we}, 32'd0);
    check("gap2 ready", {31'b0, o_ready}, 32'd1);
    check("gap2 count", {21'b0, o_count}, 32'd2);
    check("gap2 error", {31'b0, o_error}, 32'd1);
    check("gap2 cpu_en", {31'b0, o_cpu_en}, 32'd0);
    send("lui", 5'd21, 5'd5, 5'd6, 5'd0, 16'h1234, 26'h0, 1'b1, 11'd2, 32'h3C061234);
    @(negedge clk);
    check("s3 done", {31'b0, o_done}, 32'd1);
    check("s3 count", {21'b0, o_count}, 32'd3);
    check("s3 error", {31'b0, o_error}, 32'd1);
    @(negedge clk);
    pulse_start();
    check("s4 error clr", {31'b0, o_error}, 32'd0);
    check("s4 count clr", {21'b0, o_count}, 32'd0);

    // Session 4: reset after three accepts
    send("jr",   5'd13, 5'd31, 5'd0, 5'd0, 16'h0000, 26'h0, 1'b0, 11'd0, 32'h03E00008);
    send("sllv", 5'd10, 5'd4, 5'd5, 5'd6, 16'h0000, 26'h0, 1'b0, 11'd1, 32'h00853004);
    send("jal",  5'd27, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 1'b0, 11'd2, 32'h0FFFFFFF);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst cpu_en", {31'b0, o_cpu_en}, 32'd0);
    check("post rst ready", {31'b0, o_ready}, 32'd0);

    // Session 5: overflow on the AWIDTH=2 instance
    use_small = 1'b1;
    #1;
    check("small idle cpu_en", {31'b0, o_cpu_en}, 32'd0);
    pulse_start();
    send("ov addu", 5'd1,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 11'd0, 32'h00221821);
    send("ov sub",  5'd2,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0, 1'b0, 11'd1, 32'h00000022);
    send("ov lw",   5'd14, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 11'd2, 32'h8FA80004);
    check("ov no err yet", {31'b0, o_error}, 32'd0);
    send("ov sw",   5'd15, 5'd29, 5'd9, 5'd0, 16'h0008, 26'h0, 1'b0, 11'd3, 32'hAFA90008);
    check("ov ready low", {31'b0, o_ready}, 32'd0);
    @(negedge clk);
    check("ov done", {31'b0, o_done}, 32'd1);
    check("ov error", {31'b0, o_error}, 32'd1);
    check("ov count", {21'b0, o_count}, 32'd4);
    check("ov cpu_en", {31'b0, o_cpu_en}, 32'd1);
    check("ov we", {31'b0, o_we}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
